// File: rtl/var_shift_reg_if.sv
// var_shift_reg_if: control/data bundle for the serial variable-distance shifter
//   en     start/run request (level), driven by master
//   dir    0 = shift left (toward MSB), 1 = shift right (toward LSB)
//   in     word loaded at start
//   shift  requested shift distance, unsigned
//   q      shift register contents, driven by slave
//   busy   high while shifting
//   done   one-cycle pulse after the final shift
interface var_shift_reg_if #(parameter int WIDTH = 32);
    logic             en;
    logic             dir;
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] shift;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
    modport master (output en, dir, in, shift, input q, busy, done);
    modport slave  (input en, dir, in, shift, output q, busy, done);
endinterface

// File: rtl/var_shift_reg.sv
// var_shift_reg: bit-serial shifter, one bit per clock for min(shift, WIDTH) clocks
//   clk  rising-edge clock
//   clr  asynchronous active-high reset
//   b    var_shift_reg_if.slave (en, dir, in, shift in; q, busy, done out)
module var_shift_reg #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic            clk,
    input logic            clr,
    var_shift_reg_if.slave b
);
    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             dir_r;
    logic [CNT_W-1:0] sat;
    // Distances at or beyond the word width all clear the word, so cap the count there.
    assign sat = (b.shift >= $unsigned(WIDTH)) ? CNT_W'(WIDTH) : b.shift[CNT_W-1:0];
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state  <= IDLE;
            cnt    <= '0;
            dir_r  <= 1'b0;
            b.q    <= '0;
            b.busy <= 1'b0;
            b.done <= 1'b0;
        end else begin
            b.done <= 1'b0;
            case (state)
                IDLE: if (b.en) begin
                    b.q   <= b.in;
                    dir_r <= b.dir;
                    cnt   <= sat;
                    if (sat == '0) begin
                        state  <= HOLD;
                        b.done <= 1'b1;
                    end else begin
                        state  <= SHIFT;
                        b.busy <= 1'b1;
                    end
                end
                // en low pauses the shift with q and cnt frozen.
                SHIFT: if (b.en) begin
                    b.q <= dir_r ? {1'b0, b.q[WIDTH-1:1]} : {b.q[WIDTH-2:0], 1'b0};
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state  <= HOLD;
                        b.busy <= 1'b0;
                        b.done <= 1'b1;
                    end
                end
                // A held en must not retrigger; wait for it to drop.
                HOLD: if (!b.en) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_var_shift_reg.sv
// tb_var_shift_reg: directed and random checks of var_shift_reg against an arithmetic model
module tb_var_shift_reg;
    logic clk = 1'b0;
    logic clr = 1'b1;
    int   checks = 0;
    int   errors = 0;

    var_shift_reg_if vif ();
    var_shift_reg dut (.clk(clk), .clr(clr), .b(vif));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Model: after k shifts the word is simply d shifted by k; N saturates at 32.
    task automatic run(input logic [31:0] d, input logic dr, input logic [31:0] s,
                       input int pause_at, input int pause_len, input bit scramble);
        int n;
        logic [31:0] hold_q;
        logic [31:0] want;
        n = (s >= 32) ? 32 : int'(s);
        vif.en = 1'b0;
        step();
        vif.in = d;
        vif.dir = dr;
        vif.shift = s;
        vif.en = 1'b1;
        step();
        chk("load_q", vif.q, d);
        chk("load_busy", 32'(vif.busy), 32'(n > 0));
        chk("load_done", 32'(vif.done), 32'(n == 0));
        for (int k = 1; k <= n; k++) begin
            if (k - 1 == pause_at && pause_len > 0) begin
                vif.en = 1'b0;
                for (int p = 0; p < pause_len; p++) begin
                    hold_q = vif.q;
                    step();
                    chk("pause_q", vif.q, hold_q);
                    chk("pause_busy", 32'(vif.busy), 32'd1);
                end
                vif.en = 1'b1;
            end
            if (scramble) begin
                vif.dir = ~vif.dir;
                vif.in = $urandom;
                vif.shift = $urandom;
            end
            step();
            want = dr ? (d >> k) : (d << k);
            chk("shift_q", vif.q, want);
            chk("shift_busy", 32'(vif.busy), 32'(k < n));
            chk("shift_done", 32'(vif.done), 32'(k == n));
        end
        want = dr ? (d >> n) : (d << n);
        for (int h = 0; h < 2; h++) begin
            vif.in = $urandom;
            step();
            chk("hold_q", vif.q, want);
            chk("hold_busy", 32'(vif.busy), 32'd0);
            chk("hold_done", 32'(vif.done), 32'd0);
        end
    endtask

    initial begin
        vif.en = 1'b0;
        vif.dir = 1'b0;
        vif.in = '0;
        vif.shift = '0;
        #12;
        chk("rst_q", vif.q, 32'h0);
        chk("rst_busy", 32'(vif.busy), 32'd0);
        chk("rst_done", 32'(vif.done), 32'd0);
        clr = 1'b0;
        step();
        run(32'h7105C1A6, 1'b0, 32'd12, -1, 0, 1'b0);
        chk("left12", vif.q, 32'h5C1A6000);
        run(32'h7105C1A6, 1'b1, 32'd12, -1, 0, 1'b1);
        chk("right12", vif.q, 32'h0007105C);
        run(32'h7105C1A6, 1'b0, 32'd0, -1, 0, 1'b0);
        chk("zero", vif.q, 32'h7105C1A6);
        run(32'h7105C1A6, 1'b0, 32'd40, -1, 0, 1'b0);
        chk("sat40", vif.q, 32'h0);
        run(32'h7105C1A6, 1'b0, 32'd12, 6, 3, 1'b0);
        chk("pause12", vif.q, 32'h5C1A6000);
        run(32'h0000FFFF, 1'b0, 32'd16, -1, 0, 1'b0);
        chk("rearm16", vif.q, 32'hFFFF0000);
        // Abort mid-shift with an asynchronous clear between edges.
        vif.en = 1'b0;
        step();
        vif.in = 32'hDEADBEEF;
        vif.dir = 1'b1;
        vif.shift = 32'd20;
        vif.en = 1'b1;
        repeat (5) step();
        chk("pre_abort_busy", 32'(vif.busy), 32'd1);
        #2 clr = 1'b1;
        #1;
        chk("abort_q", vif.q, 32'h0);
        chk("abort_busy", 32'(vif.busy), 32'd0);
        chk("abort_done", 32'(vif.done), 32'd0);
        vif.en = 1'b0;
        step();
        clr = 1'b0;
        run(32'hA5A5_0F0F, 1'b1, 32'd7, -1, 0, 1'b0);
        chk("post_abort", vif.q, 32'h014B4A1E);
        for (int r = 0; r < 20; r++) begin
            logic [31:0] s;
            s = (r % 5 == 4) ? $urandom : 32'($urandom_range(0, 40));
            run($urandom, 1'($urandom), s, ((r % 3) == 0) ? int'($urandom_range(0, 3)) : -1,
                int'($urandom_range(1, 3)), 1'($urandom));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/var_shift_reg.md
Name: var_shift_reg

Overview:
Serial variable-distance 32-bit shift register. On a start request it loads a word, then shifts it one bit position per clock, left or right, for a programmed number of cycles. It then holds the result until the request is withdrawn. It is used as a bit-serial alignment/shift engine where area matters more than latency.

Parameters:
WIDTH, 32, data width of in/q. Fixed at 32 for this revision; the bench uses the default.
CNT_W, 6, shift-counter width. Must hold the value WIDTH.

Ports:
clk    input   1      rising-edge clock
clr    input   1      asynchronous active-high reset
en     input   1      start/run request (level)
dir    input   1      shift direction: 0 = left (toward MSB), 1 = right (toward LSB)
in     input   32     word loaded at start
shift  input   32     requested shift distance, unsigned
q      output  32     shift register contents
busy   output  1      high while shifting
done   output  1      one-cycle pulse when the final shift has completed

Behaviour:
- Reset (clr=1, asynchronous, overrides everything):
  - q=0, counter=0, state=IDLE, busy=0, done=0.
  - Takes effect immediately, including mid-shift; no partial result survives.
- State IDLE:
  - q holds its value.
  - On a clock edge with en=1:
    - q <= in.
    - Latch dir internally.
    - counter <= min(shift, 32): any value >= 32 saturates to 32; shift is treated as unsigned.
    - If the saturated count is 0, go to HOLD and pulse done.
    - Otherwise go to SHIFT.
- State SHIFT (busy=1):
  - Each edge with en=1:
    - q shifts one bit in the latched direction with zero fill. Left: q <= {q[30:0],1'b0}. Right: q <= {1'b0,q[31:1]}.
    - counter decrements.
    - On the edge where counter goes 1->0, go to HOLD and assert done for the following cycle.
  - Edge with en=0: pause. q and counter hold; stay in SHIFT; busy stays 1.
  - Changes on dir, in or shift during SHIFT are ignored.
- State HOLD:
  - busy=0; q holds the final result.
  - Stays in HOLD while en=1, so a held en does not retrigger.
  - en=0 at an edge -> IDLE. A new operation needs en to go low for at least one edge, then high again.
- done:
  - Registered; high for exactly one cycle.
  - The cycle after the load edge when shift=0.
  - The cycle after the final shift edge otherwise.
- Latency: for N = min(shift,32) >= 1 with en held high, q holds in<<N (or in>>N) after N+1 rising edges counted from the first edge that samples en=1.
- Saturation: N=32 always yields q=0 after 32 shifts.
- busy is 0 in IDLE and HOLD, and 1 in SHIFT only.

Test Plan:
1. Reset: assert clr mid-cycle with q nonzero -> q=0, busy=0, done=0 immediately, before any clock edge.
2. Left 12: in=0x7105C1A6, dir=0, shift=12, en=1 from an idle edge.
   - After 13 edges q=0x5C1A6000.
   - busy high for 12 cycles; one done pulse.
   - q is stable afterwards while en stays high.
3. Right 12: same word, dir=1 -> q=0x0007105C after 13 edges.
   - Toggling dir during the shift does not change the result.
4. Zero and saturation:
   - shift=0 -> q=0x7105C1A6 after 1 edge, done pulses, busy never high.
   - shift=40 -> busy for 32 cycles, final q=0x00000000.
5. Pause: deassert en for 3 cycles midway through a 12-bit left shift.
   - q and busy hold during the pause.
   - Final q is still 0x5C1A6000, reached 3 cycles later.
6. Re-arm and abort:
   - After done, drop en for one edge, then start in=0x0000FFFF, dir=0, shift=16 -> q=0xFFFF0000.
   - Assert clr during a second run -> q=0 and IDLE; a new start works normally.
